// File: rtl/draw_field_sync_if.sv
// Snapshot handshake between game logic and the frame-sync controller.
// Game logic drives the master side; the controller is the slave.
interface draw_field_sync_if #(
    parameter int ROW_CNT = 20,
    parameter int COL_CNT = 10,
    parameter int COLOR_W = 3
);
    localparam int FW = ROW_CNT * COL_CNT * COLOR_W;

    logic               valid;
    logic               ready;
    logic [FW-1:0]      field;
    logic               next_en;
    logic [ROW_CNT-1:0] clr_rows;

    modport master (
        output valid,
        output field,
        output next_en,
        output clr_rows,
        input  ready
    );

    modport slave (
        input  valid,
        input  field,
        input  next_en,
        input  clr_rows,
        output ready
    );
endinterface

// File: rtl/draw_field_sync.sv
// Commits game-logic field snapshots to the renderer on vblank only,
// and runs the line-clear blink animation in whole-frame steps.
module draw_field_sync #(
    parameter int ROW_CNT      = 20,
    parameter int COL_CNT      = 10,
    parameter int COLOR_W      = 3,
    parameter int BLINK_FRAMES = 4,
    parameter int BLINK_CNT    = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    draw_field_sync_if.slave     upd,
    input  logic                 vblank_i,
    output logic [ROW_CNT*COL_CNT*COLOR_W-1:0] disp_field_o,
    output logic                 disp_next_en_o,
    output logic                 anim_busy_o,
    output logic                 anim_done_o
);
    localparam int FW = ROW_CNT * COL_CNT * COLOR_W;
    localparam int RW = COL_CNT * COLOR_W;
    localparam int CW = $clog2(BLINK_FRAMES + 1);
    localparam int PW = $clog2(BLINK_CNT + 1);
    localparam logic [CW-1:0] FLAST = CW'(BLINK_FRAMES - 1);
    localparam logic [PW-1:0] PLAST = PW'(BLINK_CNT - 1);

    typedef enum logic [1:0] {IDLE, PEND, ANIM} state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      pf_q, pf_d;
    logic               pn_q, pn_d;
    logic [ROW_CNT-1:0] pc_q, pc_d;
    logic [FW-1:0]      df_q, df_d;
    logic               dn_q, dn_d;
    logic [ROW_CNT-1:0] dc_q, dc_d;
    logic               off_q, off_d;
    logic [CW-1:0]      frame_q, frame_d;
    logic [PW-1:0]      pair_q, pair_d;
    logic               done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pf_q    <= '0;
            pn_q    <= 1'b0;
            pc_q    <= '0;
            df_q    <= '0;
            dn_q    <= 1'b0;
            dc_q    <= '0;
            off_q   <= 1'b0;
            frame_q <= '0;
            pair_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pf_q    <= pf_d;
            pn_q    <= pn_d;
            pc_q    <= pc_d;
            df_q    <= df_d;
            dn_q    <= dn_d;
            dc_q    <= dc_d;
            off_q   <= off_d;
            frame_q <= frame_d;
            pair_q  <= pair_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pf_d    = pf_q;
        pn_d    = pn_q;
        pc_d    = pc_q;
        df_d    = df_q;
        dn_d    = dn_q;
        dc_d    = dc_q;
        off_d   = off_q;
        frame_d = frame_q;
        pair_d  = pair_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (upd.valid) begin
                    pf_d    = upd.field;
                    pn_d    = upd.next_en;
                    pc_d    = upd.clr_rows;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (vblank_i) begin
                    df_d    = pf_q;
                    dn_d    = pn_q;
                    dc_d    = pc_q;
                    off_d   = 1'b1;
                    frame_d = '0;
                    pair_d  = '0;
                    state_d = (pc_q == '0) ? IDLE : ANIM;
                end
            end
            ANIM: begin
                if (vblank_i) begin
                    if (frame_q == FLAST) begin
                        frame_d = '0;
                        off_d   = ~off_q;
                        // End of an ON half closes one blink pair
                        if (!off_q) begin
                            if (pair_q == PLAST) begin
                                off_d   = 1'b0;
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                pair_d = pair_q + 1'b1;
                            end
                        end
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        disp_field_o = df_q;
        if (state_q == ANIM && off_q) begin
            for (int r = 0; r < ROW_CNT; r++) begin
                if (dc_q[r]) disp_field_o[r*RW +: RW] = '0;
            end
        end
    end

    assign upd.ready      = (state_q == IDLE);
    assign disp_next_en_o = dn_q;
    assign anim_busy_o    = (state_q == ANIM);
    assign anim_done_o    = done_q;
endmodule

// File: tb/tb_draw_field_sync.sv
// Randomized bench for draw_field_sync with a frame-count reference model.
// Expected display is derived from the number of vblanks since commit.
module tb_draw_field_sync;
    localparam int ROW   = 20;
    localparam int COL   = 10;
    localparam int CW    = 3;
    localparam int BF    = 2;
    localparam int BC    = 2;
    localparam int FW    = ROW * COL * CW;
    localparam int TOTAL = 2 * BC * BF;

    typedef logic [FW-1:0] fld_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           vblank = 1'b0;
    fld_t           disp;
    logic           disp_next;
    logic           busy;
    logic           done;
    fld_t           shown = '0;
    logic           shown_next = 1'b0;
    int             total = 0;
    int             bad = 0;

    draw_field_sync_if #(.ROW_CNT(ROW), .COL_CNT(COL), .COLOR_W(CW)) upd ();

    draw_field_sync #(
        .ROW_CNT(ROW), .COL_CNT(COL), .COLOR_W(CW),
        .BLINK_FRAMES(BF), .BLINK_CNT(BC)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .upd(upd),
        .vblank_i(vblank),
        .disp_field_o(disp),
        .disp_next_en_o(disp_next),
        .anim_busy_o(busy),
        .anim_done_o(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic fld_t rand_field(int lo);
        fld_t f;
        f = '0;
        for (int i = 0; i < ROW * COL; i++) f[i*CW +: CW] = CW'($urandom_range(lo, 7));
        return f;
    endfunction

    function automatic fld_t mask_rows(fld_t f, logic [ROW-1:0] clr);
        fld_t m;
        m = f;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                if (clr[r]) m[(r*COL+c)*CW +: CW] = '0;
        return m;
    endfunction

    // Blank during even-numbered halves of the animation window
    function automatic bit blank_at(int k);
        return (k < TOTAL) && (((k / BF) % 2) == 0);
    endfunction

    task automatic test_reset();
        upd.valid = 1'b0;
        upd.field = '0;
        upd.next_en = 1'b0;
        upd.clr_rows = '0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        total++; if (disp !== '0) begin bad++; $display("FAIL reset_disp got=%h exp=0", disp); end
        total++; if (disp_next !== 1'b0) begin bad++; $display("FAIL reset_next got=%b exp=0", disp_next); end
        total++; if (upd.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", upd.ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_basic();
        fld_t f;
        f = '0;
        f[(19*COL+0)*CW +: CW] = 3'd5;
        upd.valid = 1'b1; upd.field = f; upd.next_en = 1'b1; upd.clr_rows = '0;
        step();
        upd.valid = 1'b0; upd.field = rand_field(0); upd.next_en = 1'b0;
        total++; if (upd.ready !== 1'b0) begin bad++; $display("FAIL basic_ready_drop got=%b exp=0", upd.ready); end
        for (int i = 0; i < 3; i++) begin
            total++; if (disp !== shown) begin bad++; $display("FAIL basic_hold got=%h exp=%h", disp, shown); end
            step();
        end
        vblank = 1'b1;
        total++; if (disp !== shown) begin bad++; $display("FAIL basic_pre_vb got=%h exp=%h", disp, shown); end
        step();
        vblank = 1'b0;
        total++; if (disp !== f) begin bad++; $display("FAIL basic_commit got=%h exp=%h", disp, f); end
        total++; if (disp_next !== 1'b1) begin bad++; $display("FAIL basic_next got=%b exp=1", disp_next); end
        total++; if (upd.ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", upd.ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
        shown = f; shown_next = 1'b1;
    endtask

    task automatic test_same_cycle();
        fld_t f;
        logic n;
        f = rand_field(0);
        n = 1'($urandom_range(0, 1));
        upd.valid = 1'b1; upd.field = f; upd.next_en = n; upd.clr_rows = '0;
        vblank = 1'b1;
        step();
        upd.valid = 1'b0; vblank = 1'b0;
        total++; if (disp !== shown) begin bad++; $display("FAIL same_no_commit got=%h exp=%h", disp, shown); end
        total++; if (upd.ready !== 1'b0) begin bad++; $display("FAIL same_ready got=%b exp=0", upd.ready); end
        repeat (2) step();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        total++; if (disp !== f) begin bad++; $display("FAIL same_commit got=%h exp=%h", disp, f); end
        total++; if (disp_next !== n) begin bad++; $display("FAIL same_next got=%b exp=%b", disp_next, n); end
        shown = f; shown_next = n;
    endtask

    task automatic test_blink(input fld_t f, input logic [ROW-1:0] clr, input logic nx);
        fld_t exp_d;
        int   dones;
        int   busy_cyc;
        int   busy_exp;
        int   gap;
        dones = 0; busy_cyc = 0; busy_exp = 0;
        upd.valid = 1'b1; upd.field = f; upd.next_en = nx; upd.clr_rows = clr;
        step();
        upd.valid = 1'b0; upd.field = rand_field(0); upd.clr_rows = '0;
        repeat ($urandom_range(0, 3)) step();
        total++; if (disp !== shown) begin bad++; $display("FAIL blink_precommit got=%h exp=%h", disp, shown); end
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        for (int k = 0; k <= TOTAL; k++) begin
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                exp_d = blank_at(k) ? mask_rows(f, clr) : f;
                total++; if (disp !== exp_d) begin bad++; $display("FAIL blink_disp k=%0d got=%h exp=%h", k, disp, exp_d); end
                total++; if (busy !== (k < TOTAL)) begin bad++; $display("FAIL blink_busy k=%0d got=%b exp=%b", k, busy, k < TOTAL); end
                total++; if (upd.ready !== (k >= TOTAL)) begin bad++; $display("FAIL blink_ready k=%0d got=%b exp=%b", k, upd.ready, k >= TOTAL); end
                total++; if (done !== (k == TOTAL && g == 0)) begin bad++; $display("FAIL blink_done k=%0d g=%0d got=%b", k, g, done); end
                total++; if (disp_next !== nx) begin bad++; $display("FAIL blink_next k=%0d got=%b exp=%b", k, disp_next, nx); end
                if (done) dones++;
                if (busy) busy_cyc++;
                if (k < TOTAL) busy_exp++;
                if (g < gap - 1) step();
            end
            if (k < TOTAL) begin
                vblank = 1'b1;
                step();
                vblank = 1'b0;
            end
        end
        total++; if (dones != 1) begin bad++; $display("FAIL blink_done_count got=%0d exp=1", dones); end
        total++; if (busy_cyc != busy_exp) begin bad++; $display("FAIL blink_busy_span got=%0d exp=%0d", busy_cyc, busy_exp); end
        shown = f; shown_next = nx;
    endtask

    task automatic test_valid_held();
        fld_t             f1, f2;
        logic [ROW-1:0]   clr1;
        f1 = rand_field(1);
        f2 = rand_field(0);
        clr1 = '0;
        clr1[$urandom_range(0, ROW-1)] = 1'b1;
        upd.valid = 1'b1; upd.field = f1; upd.next_en = 1'b1; upd.clr_rows = clr1;
        step();
        upd.field = f2; upd.next_en = 1'b0; upd.clr_rows = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (upd.ready !== 1'b0) begin bad++; $display("FAIL held_pend_ready got=%b exp=0", upd.ready); end
        end
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        total++; if (disp !== mask_rows(f1, clr1)) begin bad++; $display("FAIL held_first_commit got=%h exp=%h", disp, mask_rows(f1, clr1)); end
        total++; if (disp_next !== 1'b1) begin bad++; $display("FAIL held_first_next got=%b exp=1", disp_next); end
        for (int v = 1; v <= TOTAL; v++) begin
            step();
            total++; if (upd.ready !== 1'b0) begin bad++; $display("FAIL held_anim_ready v=%0d got=%b exp=0", v, upd.ready); end
            vblank = 1'b1;
            step();
            vblank = 1'b0;
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done got=%b exp=1", done); end
        total++; if (upd.ready !== 1'b1) begin bad++; $display("FAIL held_idle_ready got=%b exp=1", upd.ready); end
        total++; if (disp !== f1) begin bad++; $display("FAIL held_restored got=%h exp=%h", disp, f1); end
        step();
        upd.valid = 1'b0;
        total++; if (upd.ready !== 1'b0) begin bad++; $display("FAIL held_second_xfer got=%b exp=0", upd.ready); end
        total++; if (disp !== f1) begin bad++; $display("FAIL held_no_early got=%h exp=%h", disp, f1); end
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        total++; if (disp !== f2) begin bad++; $display("FAIL held_second_commit got=%h exp=%h", disp, f2); end
        total++; if (disp_next !== 1'b0) begin bad++; $display("FAIL held_second_next got=%b exp=0", disp_next); end
        shown = f2; shown_next = 1'b0;
    endtask

    task automatic test_reset_mid_anim();
        fld_t           f;
        logic [ROW-1:0] clr;
        f = rand_field(1);
        clr = ROW'($urandom) | ROW'(1);
        upd.valid = 1'b1; upd.field = f; upd.next_en = 1'b1; upd.clr_rows = clr;
        step();
        upd.valid = 1'b0;
        for (int v = 0; v < 4; v++) begin
            vblank = 1'b1;
            step();
            vblank = 1'b0;
            step();
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (disp !== '0) begin bad++; $display("FAIL rst_async_disp got=%h exp=0", disp); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
        total++; if (upd.ready !== 1'b1) begin bad++; $display("FAIL rst_async_ready got=%b exp=1", upd.ready); end
        total++; if (disp_next !== 1'b0) begin bad++; $display("FAIL rst_async_next got=%b exp=0", disp_next); end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 2 * TOTAL; i++) begin
            vblank = (i % 2 == 0);
            step();
            vblank = 1'b0;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_no_done i=%0d got=%b", i, done); end
            total++; if (disp !== '0) begin bad++; $display("FAIL rst_discard i=%0d got=%h exp=0", i, disp); end
        end
        shown = '0; shown_next = 1'b0;
    endtask

    initial begin
        fld_t           f;
        logic [ROW-1:0] clr;
        test_reset();
        test_basic();
        test_same_cycle();
        f = rand_field(0);
        for (int c = 0; c < COL; c++) f[(18*COL+c)*CW +: CW] = 3'd3;
        clr = '0;
        clr[18] = 1'b1;
        test_blink(f, clr, 1'b1);
        test_valid_held();
        test_blink(rand_field(1), '1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) begin
            clr = ROW'($urandom) | ROW'(1 << $urandom_range(0, ROW-1));
            test_blink(rand_field(0), clr, 1'($urandom_range(0, 1)));
        end
        test_reset_mid_anim();
        test_same_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
